gppcu_mc_lane_sequencer: RTL and testbench

//  Parametrised multi-cycle functional-unit sequencer shared by NUM_LANES GPPCU threads in the EXEC stage.

---
 rtl/gppcu_mc_lane_sequencer_if.sv | 33 +++
 rtl/gppcu_mc_lane_sequencer.sv | 134 +++++++++++++
 tb/tb_gppcu_mc_lane_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/gppcu_mc_lane_sequencer_if.sv
// EXEC-side handshake and per-lane unit bus of the multi-cycle lane sequencer.
// The sequencer uses the slave modport; EXEC/units drive the master side.
interface gppcu_mc_lane_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int DBW       = 32,
  parameter int OPC_BITS  = 3
);
  logic                     iVALID;
  logic [OPC_BITS-1:0]      iOPC;
  logic [NUM_LANES-1:0]     iLANE_EN;
  logic [NUM_LANES*DBW-1:0] iOPR_A;
  logic [NUM_LANES*DBW-1:0] iOPR_B;
  logic                     oBUSY;
  logic [NUM_LANES-1:0]     oFU_START;
  logic [OPC_BITS-1:0]      oFU_OPC;
  logic [NUM_LANES*DBW-1:0] oFU_DA;
  logic [NUM_LANES*DBW-1:0] oFU_DB;
  logic [NUM_LANES-1:0]     iFU_DONE;
  logic [NUM_LANES*DBW-1:0] iFU_Q;
  logic [NUM_LANES*DBW-1:0] oRESULT;
  logic                     oDONE;
  logic                     oTIMEOUT;

  modport slave (
    input  iVALID, iOPC, iLANE_EN, iOPR_A, iOPR_B, iFU_DONE, iFU_Q,
    output oBUSY, oFU_START, oFU_OPC, oFU_DA, oFU_DB, oRESULT, oDONE, oTIMEOUT
  );

  modport master (
    output iVALID, iOPC, iLANE_EN, iOPR_A, iOPR_B, iFU_DONE, iFU_Q,
    input  oBUSY, oFU_START, oFU_OPC, oFU_DA, oFU_DB, oRESULT, oDONE, oTIMEOUT
  );
endinterface

// File: rtl/gppcu_mc_lane_sequencer.sv
// Lockstep multi-cycle FU sequencer for NUM_LANES threads: latch, start, collect
// out-of-order per-lane completions, hold results for WB, stall EXEC meanwhile.
module gppcu_mc_lane_sequencer #(
  parameter int NUM_LANES   = 4,
  parameter int DBW         = 32,
  parameter int OPC_BITS    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                            iACLK,
  input  logic                            iRST,
  gppcu_mc_lane_sequencer_if.slave        bus
);
  localparam int CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  typedef logic [NUM_LANES-1:0][DBW-1:0] lane_vec_t;

  state_e               state_q, state_d;
  logic [OPC_BITS-1:0]  opc_q, opc_d;
  lane_vec_t            da_q, da_d;
  lane_vec_t            db_q, db_d;
  lane_vec_t            res_q, res_d;
  lane_vec_t            fu_q;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [NUM_LANES-1:0] start_q, start_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;

  assign fu_q = bus.iFU_Q;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    da_d    = da_q;
    db_d    = db_q;
    res_d   = res_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    start_d = '0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.iVALID) begin
          tmo_d = 1'b0;
          if (|bus.iLANE_EN) begin
            opc_d   = bus.iOPC;
            da_d    = bus.iOPR_A;
            db_d    = bus.iOPR_B;
            mask_d  = bus.iLANE_EN;
            res_d   = '0;
            start_d = bus.iLANE_EN;
            state_d = S_ISSUE;
          end else begin
            // fully masked op: nothing to run, just retire it
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        pend_d  = mask_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (pend_q[i] && bus.iFU_DONE[i]) res_d[i] = fu_q[i];
        end
        pend_d = pend_q & ~bus.iFU_DONE;
        // completion is checked before the timeout so a last-cycle finish wins
        if (pend_d == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          tmo_d   = 1'b1;
          pend_d  = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iACLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      da_q    <= '0;
      db_q    <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      da_q    <= da_d;
      db_q    <= db_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // stall drops in DONE so EXEC advances on the oDONE cycle
  assign bus.oBUSY     = bus.iVALID & (state_q != S_DONE);
  assign bus.oFU_START = start_q;
  assign bus.oFU_OPC   = opc_q;
  assign bus.oFU_DA    = da_q;
  assign bus.oFU_DB    = db_q;
  assign bus.oRESULT   = res_q;
  assign bus.oDONE     = done_q;
  assign bus.oTIMEOUT  = tmo_q;

endmodule

// File: tb/tb_gppcu_mc_lane_sequencer.sv
// Directed + random ops against a schedule-scanning reference model of the lane sequencer.
module tb_gppcu_mc_lane_sequencer;
  localparam int NL   = 4;
  localparam int DBW  = 32;
  localparam int OPB  = 3;
  localparam int TO   = 8;
  localparam int W    = NL * DBW;
  localparam int KMAX = TO + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gppcu_mc_lane_sequencer_if #(.NUM_LANES(NL), .DBW(DBW), .OPC_BITS(OPB)) bus ();

  gppcu_mc_lane_sequencer #(
    .NUM_LANES(NL), .DBW(DBW), .OPC_BITS(OPB), .TIMEOUT_CYC(TO)
  ) dut (
    .iACLK(clk),
    .iRST (rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // done strobes / result data offered k cycles after the start cycle
  logic [NL-1:0] sd [0:KMAX];
  logic [W-1:0]  sq [0:KMAX];
  logic [W-1:0]  exp_res = '0;
  logic          exp_tmo = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DBW +: DBW] = DBW'($urandom);
    return v;
  endfunction

  // ks[i] = offset of lane i's single strobe after start; >KMAX means never
  task automatic sched_dir(input logic [NL-1:0][7:0] ks);
    for (int k = 0; k <= KMAX; k++) begin
      sd[k] = '0;
      sq[k] = rnd_w();
    end
    for (int i = 0; i < NL; i++)
      if (int'(ks[i]) <= KMAX) sd[int'(ks[i])][i] = 1'b1;
  endtask

  task automatic sched_rnd();
    for (int k = 0; k <= KMAX; k++) begin
      sd[k] = NL'($urandom) & NL'($urandom);
      sq[k] = rnd_w();
    end
  endtask

  task automatic run_op(input logic [NL-1:0] mask, input bit hold, input int rst_at);
    logic [W-1:0]   a, b, res;
    logic [OPB-1:0] opc;
    bit             tmo, found;
    int             fin, done_j;
    a   = rnd_w();
    b   = rnd_w();
    opc = OPB'($urandom);
    // reference: each enabled lane takes its first strobe in WAIT (offsets 1..TO)
    tmo = 1'b0;
    fin = 0;
    if (mask == '0) begin
      res    = exp_res;
      done_j = 1;
    end else begin
      res = '0;
      for (int i = 0; i < NL; i++) begin
        if (mask[i]) begin
          found = 1'b0;
          for (int k = 1; k <= TO; k++) begin
            if (!found && sd[k][i]) begin
              found = 1'b1;
              res[i*DBW +: DBW] = sq[k][i*DBW +: DBW];
              if (k > fin) fin = k;
            end
          end
          if (!found) tmo = 1'b1;
        end
      end
      done_j = tmo ? TO + 2 : fin + 2;
    end

    for (int j = 0; j <= done_j; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        bus.iVALID   = 1'b1;
        bus.iOPC     = opc;
        bus.iLANE_EN = mask;
        bus.iOPR_A   = a;
        bus.iOPR_B   = b;
        bus.iFU_DONE = NL'($urandom);
        bus.iFU_Q    = rnd_w();
      end else begin
        bus.iOPC     = OPB'($urandom);
        bus.iLANE_EN = NL'($urandom);
        bus.iOPR_A   = rnd_w();
        bus.iOPR_B   = rnd_w();
        bus.iFU_DONE = sd[j-1];
        bus.iFU_Q    = sq[j-1];
      end
      @(negedge clk);
      chk("busy",  128'(bus.oBUSY), 128'(j < done_j));
      chk("start", 128'(bus.oFU_START), 128'((j == 1 && mask != '0) ? mask : '0));
      chk("done",  128'(bus.oDONE), 128'(j == done_j));
      chk("tmo",   128'(bus.oTIMEOUT), 128'((j == 0) ? exp_tmo : ((j == done_j) ? tmo : 1'b0)));
      if (j == 0) chk("res_held", bus.oRESULT, exp_res);
      if (mask != '0 && (j == 1 || j == done_j)) begin
        chk("fu_opc", 128'(bus.oFU_OPC), 128'(opc));
        chk("fu_da",  bus.oFU_DA, a);
        chk("fu_db",  bus.oFU_DB, b);
      end
      if (j == done_j) chk("result", bus.oRESULT, res);
      if (j == rst_at) begin
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.iVALID = 1'b0;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.iFU_DONE = '1;
        bus.iFU_Q    = rnd_w();
        @(negedge clk);
        chk("rst_busy",  128'(bus.oBUSY), 128'(0));
        chk("rst_start", 128'(bus.oFU_START), 128'(0));
        chk("rst_done",  128'(bus.oDONE), 128'(0));
        chk("rst_tmo",   128'(bus.oTIMEOUT), 128'(0));
        chk("rst_res",   bus.oRESULT, 128'(0));
        chk("rst_da",    bus.oFU_DA, 128'(0));
        @(posedge clk); #1;
        bus.iFU_DONE = '0;
        @(negedge clk);
        chk("stale_res",  bus.oRESULT, 128'(0));
        chk("stale_done", 128'(bus.oDONE), 128'(0));
        exp_res = '0;
        exp_tmo = 1'b0;
        return;
      end
    end
    exp_res = res;
    exp_tmo = tmo;
    if (!hold) begin
      @(posedge clk); #1;
      bus.iVALID   = 1'b0;
      bus.iFU_DONE = NL'($urandom);
      bus.iFU_Q    = rnd_w();
      @(negedge clk);
      chk("idle_busy",  128'(bus.oBUSY), 128'(0));
      chk("idle_done",  128'(bus.oDONE), 128'(0));
      chk("idle_start", 128'(bus.oFU_START), 128'(0));
      chk("idle_res",   bus.oRESULT, exp_res);
    end
  endtask

  initial begin
    bus.iVALID   = 1'b0;
    bus.iOPC     = '0;
    bus.iLANE_EN = '0;
    bus.iOPR_A   = '0;
    bus.iOPR_B   = '0;
    bus.iFU_DONE = '0;
    bus.iFU_Q    = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_busy",  128'(bus.oBUSY), 128'(0));
    chk("init_start", 128'(bus.oFU_START), 128'(0));
    chk("init_done",  128'(bus.oDONE), 128'(0));
    chk("init_tmo",   128'(bus.oTIMEOUT), 128'(0));
    chk("init_res",   bus.oRESULT, 128'(0));
    chk("init_da",    bus.oFU_DA, 128'(0));
    chk("init_db",    bus.oFU_DB, 128'(0));
    chk("init_opc",   128'(bus.oFU_OPC), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // all lanes, out-of-order finish
    sched_dir({8'd3, 8'd3, 8'd5, 8'd2});
    run_op(4'hF, 1'b0, -1);
    // masked lanes 1/3 strobe early and must be ignored
    sched_dir({8'd3, 8'd4, 8'd1, 8'd2});
    run_op(4'b0101, 1'b0, -1);
    // fully masked op keeps previous results
    sched_rnd();
    run_op(4'h0, 1'b0, -1);
    // lane 2 never finishes; lane 3 finishes on the last WAIT cycle
    sched_dir({8'd8, 8'd255, 8'd6, 8'd1});
    run_op(4'hF, 1'b0, -1);
    // last lane finishes on the timeout cycle: completion wins
    sched_dir({8'd8, 8'd1, 8'd2, 8'd3});
    run_op(4'hF, 1'b0, -1);
    // back-to-back with iVALID held: timed-out op followed by a clean op
    sched_dir({8'd255, 8'd2, 8'd2, 8'd2});
    run_op(4'hF, 1'b1, -1);
    sched_dir({8'd1, 8'd4, 8'd2, 8'd3});
    run_op(4'hF, 1'b0, -1);
    // reset mid-WAIT after lane 0 has captured
    sched_dir({8'd255, 8'd255, 8'd255, 8'd1});
    run_op(4'hF, 1'b0, 3);
    // random masks, strobe patterns and hold behaviour
    for (int n = 0; n < 40; n++) begin
      sched_rnd();
      run_op(NL'($urandom), 1'($urandom_range(0, 1)), -1);
    end
    @(posedge clk); #1;
    bus.iVALID = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
